// File: rtl/p_hit_t_seq.sv
// p_hit_t_seq: ray/plane hit distance t = (n.(v0-origin)) / (n.dir), signed Q fixed point, one shared multiplier + restoring divider.
// Latency: 11+D_BITS+Q_BITS cycles write-to-out_empty-fall (zero-divisor / culled: 11); one result per 10+D_BITS+Q_BITS cycles back-to-back.
// Backpressure: in_full blocks writes (dropped); FSM stalls in WRITE while the output FIFO is full; a pop on a full output FIFO frees the push slot.
//
// Ports: clock/reset (async, active low); tri_normal/v0/origin/dir are packed x3 vectors, x in the
// low D_BITS, then y, then z; in_wr_en/in_full write side; out_t/out_hit/out_empty/out_rd_en
// first-word-fall-through read side (out_t/out_hit read 0 while empty).
// Optional macro P_HIT_CULL_BACKFACE_EN: any den >= 0 skips the divide and writes t=0, hit=0.

module p_hit_t_seq_fifo #(
    parameter int W         = 8,
    parameter int DEPTH     = 16,
    parameter bit POP_FREES = 1'b0   // 1: a pop on a full FIFO lets a same-cycle push in
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    output logic         full,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         rd_ok;
    logic         wr_ok;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_ok   = rd_en && !empty;
    assign wr_ok   = wr_en && (!full || (POP_FREES && rd_ok));
    // Gate the head so nothing stale from before a reset is ever visible.
    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
    end
endmodule

module p_hit_t_seq #(
    parameter int D_BITS    = 32,
    parameter int Q_BITS    = 16,
    parameter int IN_DEPTH  = 16,
    parameter int OUT_DEPTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [3*D_BITS-1:0]   tri_normal,
    input  logic [3*D_BITS-1:0]   v0,
    input  logic [3*D_BITS-1:0]   origin,
    input  logic [3*D_BITS-1:0]   dir,
    input  logic                  in_wr_en,
    output logic                  in_full,
    output logic [D_BITS-1:0]     out_t,
    output logic                  out_hit,
    output logic                  out_empty,
    input  logic                  out_rd_en
);
    localparam int ACC = 2*D_BITS + 3;
    localparam int QW  = D_BITS + Q_BITS;
    localparam int CW  = ($clog2(QW+1) > 3) ? $clog2(QW+1) : 3;
    localparam int DW  = D_BITS + 1;

    localparam logic [3:0] IDLE  = 4'd0;
    localparam logic [3:0] LOAD  = 4'd1;
    localparam logic [3:0] DIFF  = 4'd2;
    localparam logic [3:0] MAC   = 4'd3;
    localparam logic [3:0] SCALE = 4'd4;
    localparam logic [3:0] DIV   = 4'd5;
    localparam logic [3:0] SIGN  = 4'd6;
    localparam logic [3:0] WRITE = 4'd7;

    localparam logic [D_BITS-1:0] MAX_POS = {1'b0, {(D_BITS-1){1'b1}}};

    logic [3:0]              state;
    logic [CW-1:0]           cnt;
    logic [3*D_BITS-1:0]     n_r, v0_r, org_r, dir_r;
    logic [3*DW-1:0]         d_r;
    logic signed [ACC-1:0]   acc_num, acc_den;
    logic                    res_neg;
    logic [D_BITS-1:0]       divisor;
    logic [D_BITS-1:0]       rem;
    logic [QW-1:0]           quo;
    logic [D_BITS-1:0]       t_r;
    logic                    hit_r;

    // Input FIFO
    logic [12*D_BITS-1:0] in_head;
    logic                 in_empty;
    logic                 in_pop;

    assign in_pop = (state == LOAD);

    p_hit_t_seq_fifo #(.W(12*D_BITS), .DEPTH(IN_DEPTH), .POP_FREES(1'b0)) u_in_fifo (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (in_wr_en),
        .wr_data ({dir, origin, v0, tri_normal}),
        .full    (in_full),
        .rd_en   (in_pop),
        .rd_data (in_head),
        .empty   (in_empty)
    );

    // Output FIFO
    logic                out_full;
    logic                out_can_push;
    logic                push_en;
    logic [D_BITS-1:0]   push_t;
    logic                push_hit;
    logic [D_BITS:0]     out_head;

    // Same-cycle pop of a full FIFO frees the slot the push needs.
    assign out_can_push = !out_full || (out_rd_en && !out_empty);

    p_hit_t_seq_fifo #(.W(D_BITS+1), .DEPTH(OUT_DEPTH), .POP_FREES(1'b1)) u_out_fifo (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (push_en),
        .wr_data ({push_t, push_hit}),
        .full    (out_full),
        .rd_en   (out_rd_en),
        .rd_data (out_head),
        .empty   (out_empty)
    );

    assign {out_t, out_hit} = out_head;

    // Shared multiplier: steps 0..2 build n.d, steps 3..5 build n.dir.
    logic signed [D_BITS-1:0] mul_a;
    logic signed [DW-1:0]     mul_b;
    logic signed [2*D_BITS:0] ext_a, ext_b, prod;
    logic signed [ACC-1:0]    prod_ext;

    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (cnt[2:0])
            3'd0: begin mul_a = n_r[0 +: D_BITS];        mul_b = d_r[0 +: DW];    end
            3'd1: begin mul_a = n_r[D_BITS +: D_BITS];   mul_b = d_r[DW +: DW];   end
            3'd2: begin mul_a = n_r[2*D_BITS +: D_BITS]; mul_b = d_r[2*DW +: DW]; end
            3'd3: begin mul_a = n_r[0 +: D_BITS];
                        mul_b = {dir_r[D_BITS-1], dir_r[0 +: D_BITS]}; end
            3'd4: begin mul_a = n_r[D_BITS +: D_BITS];
                        mul_b = {dir_r[2*D_BITS-1], dir_r[D_BITS +: D_BITS]}; end
            3'd5: begin mul_a = n_r[2*D_BITS +: D_BITS];
                        mul_b = {dir_r[3*D_BITS-1], dir_r[2*D_BITS +: D_BITS]}; end
            default: begin mul_a = '0; mul_b = '0; end
        endcase
        ext_a    = $signed({{(D_BITS+1){mul_a[D_BITS-1]}}, mul_a});
        ext_b    = $signed({{D_BITS{mul_b[DW-1]}}, mul_b});
        prod     = ext_a * ext_b;
        prod_ext = $signed({{2{prod[2*D_BITS]}}, prod});
    end

    // Back from Q(2*Q_BITS) products to Q(Q_BITS), clamped to a D_BITS word.
    function automatic logic [D_BITS-1:0] sat_d(input logic signed [ACC-1:0] x);
        logic [D_BITS-1:0] r;
        if ((&x[ACC-1:D_BITS-1]) || !(|x[ACC-1:D_BITS-1]))
            r = x[D_BITS-1:0];
        else if (x[ACC-1])
            r = {1'b1, {(D_BITS-1){1'b0}}};
        else
            r = MAX_POS;
        return r;
    endfunction

    logic signed [ACC-1:0] num_sh, den_sh;
    logic [D_BITS-1:0]     num_s, den_s, num_abs, den_abs;
    logic                  skip_div;
    logic [D_BITS-1:0]     skip_t;

    always_comb begin
        num_sh  = acc_num >>> Q_BITS;
        den_sh  = acc_den >>> Q_BITS;
        num_s   = sat_d(num_sh);
        den_s   = sat_d(den_sh);
        // The most negative value maps onto 2^(D_BITS-1) as an unsigned magnitude.
        num_abs = num_s[D_BITS-1] ? (~num_s + D_BITS'(1)) : num_s;
        den_abs = den_s[D_BITS-1] ? (~den_s + D_BITS'(1)) : den_s;
`ifdef P_HIT_CULL_BACKFACE_EN
        skip_div = !den_s[D_BITS-1];
        skip_t   = '0;
`else
        skip_div = (den_s == '0);
        skip_t   = MAX_POS;
`endif
    end

    // One restoring-division step: the dividend shifts out of quo's top while quotient bits shift in.
    logic [D_BITS:0]   rem_sh;
    logic              q_bit;
    logic [D_BITS-1:0] rem_nx;
    logic [QW-1:0]     quo_nx;

    always_comb begin
        rem_sh = {rem, quo[QW-1]};
        q_bit  = (rem_sh >= {1'b0, divisor});
        rem_nx = q_bit ? D_BITS'(rem_sh - {1'b0, divisor}) : rem_sh[D_BITS-1:0];
        quo_nx = {quo[QW-2:0], q_bit};
    end

    logic [D_BITS-1:0] mag, sign_t;
    logic              sign_hit;

    always_comb begin
        mag      = (|quo[QW-1:D_BITS-1]) ? MAX_POS : quo[D_BITS-1:0];
        sign_t   = res_neg ? (~mag + D_BITS'(1)) : mag;
        sign_hit = !res_neg && (mag != '0);
    end

    // SIGN pushes directly when it can; WRITE only retries a stalled push.
    assign push_en  = ((state == SIGN) || (state == WRITE)) && out_can_push;
    assign push_t   = (state == SIGN) ? sign_t : t_r;
    assign push_hit = (state == SIGN) ? sign_hit : hit_r;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            n_r     <= '0;
            v0_r    <= '0;
            org_r   <= '0;
            dir_r   <= '0;
            d_r     <= '0;
            acc_num <= '0;
            acc_den <= '0;
            res_neg <= 1'b0;
            divisor <= '0;
            rem     <= '0;
            quo     <= '0;
            t_r     <= '0;
            hit_r   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (!in_empty) state <= LOAD;
                LOAD: begin
                    {dir_r, org_r, v0_r, n_r} <= in_head;
                    state <= DIFF;
                end
                DIFF: begin
                    for (int i = 0; i < 3; i++)
                        d_r[i*DW +: DW] <= {v0_r[i*D_BITS + D_BITS-1], v0_r[i*D_BITS +: D_BITS]}
                                         - {org_r[i*D_BITS + D_BITS-1], org_r[i*D_BITS +: D_BITS]};
                    acc_num <= '0;
                    acc_den <= '0;
                    cnt     <= '0;
                    state   <= MAC;
                end
                MAC: begin
                    if (cnt < CW'(3)) acc_num <= acc_num + prod_ext;
                    else              acc_den <= acc_den + prod_ext;
                    if (cnt == CW'(5)) begin
                        cnt   <= '0;
                        state <= SCALE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                SCALE: begin
                    res_neg <= num_s[D_BITS-1] ^ den_s[D_BITS-1];
                    divisor <= den_abs;
                    rem     <= '0;
                    quo     <= {num_abs, {Q_BITS{1'b0}}};
                    cnt     <= '0;
                    if (skip_div) begin
                        t_r   <= skip_t;
                        hit_r <= 1'b0;
                        state <= WRITE;
                    end else begin
                        state <= DIV;
                    end
                end
                DIV: begin
                    rem <= rem_nx;
                    quo <= quo_nx;
                    if (cnt == CW'(QW-1)) begin
                        cnt   <= '0;
                        state <= SIGN;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                SIGN: begin
                    t_r   <= sign_t;
                    hit_r <= sign_hit;
                    if (out_can_push) state <= in_empty ? IDLE : LOAD;
                    else              state <= WRITE;
                end
                WRITE: if (out_can_push) state <= in_empty ? IDLE : LOAD;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
